// File: rtl/cpu_mem_responder_if.sv
// CPU-side memory bus between the execute engine (master) and the memory responder (slave).
// Address, write data and strobes flow toward the responder; read data and the DMA stall flow back.
interface cpu_mem_responder_if;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_write_en;
    logic        mem_read_en;
    logic        cpu_stall;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_write_en,
        output mem_read_en,
        input  mem_rdata,
        input  cpu_stall
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_write_en,
        input  mem_read_en,
        output mem_rdata,
        output cpu_stall
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Memory-bus target for the CPU: decodes RAM / PPU / PRG windows, registers read data every cycle,
// and runs the 256-byte OAM DMA engine that owns the bus (and stalls the CPU) while active.
module cpu_mem_responder #(
    parameter int          RAM_AW   = 11,
    parameter int          PRG_AW   = 15,
    parameter logic [15:0] DMA_ADDR = 16'h4014,
    parameter logic [2:0]  OAM_REG  = 3'd4
) (
    input  logic               clk,
    input  logic               rst_n,
    cpu_mem_responder_if.slave bus,
    output logic [2:0]         ppu_reg_addr_o,
    output logic [7:0]         ppu_wr_data_o,
    output logic               ppu_wr_en_o,
    output logic               ppu_rd_en_o,
    input  logic [7:0]         ppu_rd_data_i,
    output logic [PRG_AW-1:0]  prg_addr_o,
    input  logic [7:0]         prg_data_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DMA_RD = 2'd1,
        DMA_WR = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  dma_page_q;
    logic [7:0]  dma_idx_q;
    logic [7:0]  dma_idx_d;
    logic [7:0]  dma_buf_q;
    logic [7:0]  mem_rdata_q;
    logic        cpu_stall_q;

    logic [7:0]  ram_mem [2**RAM_AW];

    logic        cpu_owns_bus;
    logic [15:0] bus_addr;
    logic        in_ram_win;
    logic        in_ppu_win;
    logic        in_prg_win;
    logic [7:0]  lookup_data;
    logic        cpu_wr;
    logic        cpu_rd;
    logic        ram_we;
    logic        dma_start;

    // The DMA engine substitutes its own address for the CPU's while it is running.
    assign cpu_owns_bus = (state_q == IDLE);
    assign bus_addr     = cpu_owns_bus ? bus.mem_addr : {dma_page_q, dma_idx_q};

    assign in_ram_win = (bus_addr[15:13] == 3'b000);
    assign in_ppu_win = (bus_addr[15:13] == 3'b001);
    assign in_prg_win = bus_addr[15];

    assign cpu_wr    = cpu_owns_bus & bus.mem_write_en;
    assign cpu_rd    = cpu_owns_bus & bus.mem_read_en & ~bus.mem_write_en;
    assign ram_we    = cpu_wr & in_ram_win;
    assign dma_start = cpu_wr & (bus.mem_addr == DMA_ADDR);
    assign dma_idx_d = dma_idx_q + 8'd1;

    always_comb begin
        lookup_data = 8'h00;
        if (in_ram_win) begin
            lookup_data = ram_mem[bus_addr[RAM_AW-1:0]];
        end else if (in_ppu_win) begin
            lookup_data = ppu_rd_data_i;
        end else if (in_prg_win) begin
            lookup_data = prg_data_i;
        end
    end

    assign prg_addr_o = bus_addr[PRG_AW-1:0];

    // DMA_WR steers the PPU port to OAMDATA; otherwise it mirrors the CPU access.
    always_comb begin
        ppu_reg_addr_o = bus_addr[2:0];
        ppu_wr_data_o  = bus.mem_wdata;
        ppu_wr_en_o    = cpu_wr & in_ppu_win;
        ppu_rd_en_o    = cpu_rd & in_ppu_win;
        if (state_q == DMA_WR) begin
            ppu_reg_addr_o = OAM_REG;
            ppu_wr_data_o  = dma_buf_q;
            ppu_wr_en_o    = 1'b1;
        end
    end

    // RAM contents survive reset, so the array has no reset term.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_mem[bus_addr[RAM_AW-1:0]] <= bus.mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dma_page_q  <= 8'h00;
            dma_idx_q   <= 8'h00;
            dma_buf_q   <= 8'h00;
            mem_rdata_q <= 8'h00;
            cpu_stall_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    mem_rdata_q <= lookup_data;
                    if (dma_start) begin
                        dma_page_q  <= bus.mem_wdata;
                        dma_idx_q   <= 8'h00;
                        state_q     <= DMA_RD;
                        cpu_stall_q <= 1'b1;
                    end
                end
                DMA_RD: begin
                    dma_buf_q <= lookup_data;
                    state_q   <= DMA_WR;
                end
                DMA_WR: begin
                    dma_idx_q <= dma_idx_d;
                    if (dma_idx_q == 8'hFF) begin
                        state_q     <= IDLE;
                        cpu_stall_q <= 1'b0;
                    end else begin
                        state_q <= DMA_RD;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cpu_stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_rdata = mem_rdata_q;
    assign bus.cpu_stall = cpu_stall_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomized scoreboard bench for cpu_mem_responder: a per-cycle reference model pushes expectations,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  ppu_reg_addr;
    logic [7:0]  ppu_wr_data;
    logic        ppu_wr_en;
    logic        ppu_rd_en;
    logic [7:0]  ppu_rd_data;
    logic [14:0] prg_addr;
    logic [7:0]  prg_data;

    always #5 clk = ~clk;

    cpu_mem_responder_if bus_if ();

    cpu_mem_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus_if),
        .ppu_reg_addr_o (ppu_reg_addr),
        .ppu_wr_data_o  (ppu_wr_data),
        .ppu_wr_en_o    (ppu_wr_en),
        .ppu_rd_en_o    (ppu_rd_en),
        .ppu_rd_data_i  (ppu_rd_data),
        .prg_addr_o     (prg_addr),
        .prg_data_i     (prg_data)
    );

    function automatic logic [7:0] ppu_fn(input logic [2:0] r);
        return {5'b10110, r} ^ 8'h0F;
    endfunction

    function automatic logic [7:0] prg_fn(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
    endfunction

    assign ppu_rd_data = ppu_fn(ppu_reg_addr);
    assign prg_data    = prg_fn(prg_addr);

    typedef struct {
        int          cyc;
        logic        stall;
        logic        wr_en;
        logic        rd_en;
        logic        chk_port;
        logic        chk_prg;
        logic [2:0]  reg_a;
        logic [7:0]  wd;
        logic [7:0]  rdata;
        logic [14:0] prg;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;

    // Reference state: memory image, the CPU-visible read register, and DMA progress.
    logic [7:0] ram_m [2048];
    logic [7:0] rdata_m;
    int         dma_left;
    logic [7:0] dma_page;

    function automatic logic [7:0] lookup(input logic [15:0] a);
        if (a < 16'h2000) return ram_m[a[10:0]];
        if (a < 16'h4000) return ppu_fn(a[2:0]);
        if (a < 16'h8000) return 8'h00;
        return prg_fn(a[14:0]);
    endfunction

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom_range(0, 16'h1FFF));
            1:       return 16'h2000 + 16'($urandom_range(0, 16'h1FFF));
            2:       return 16'h4000 + 16'($urandom_range(0, 16'h3FFF));
            default: return 16'h8000 + 16'($urandom_range(0, 16'h7FFF));
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, expv);
        end
    endtask

    // One bus cycle: drive inputs just after the edge and record what the DUT must show this cycle.
    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic we, input logic re);
        exp_t e;
        int   k;
        @(posedge clk);
        #1;
        cyc++;
        bus_if.mem_addr     = a;
        bus_if.mem_wdata    = d;
        bus_if.mem_write_en = we;
        bus_if.mem_read_en  = re;
        e.cyc   = cyc;
        e.stall = (dma_left > 0);
        e.rdata = rdata_m;
        if (dma_left > 0) begin
            k          = 512 - dma_left;
            e.rd_en    = 1'b0;
            e.chk_prg  = 1'b0;
            e.prg      = '0;
            e.wr_en    = (k % 2 == 1);
            e.chk_port = (k % 2 == 1);
            e.reg_a    = 3'd4;
            e.wd       = lookup({dma_page, 8'(k / 2)});
            dma_left--;
        end else begin
            e.wr_en    = we && (a[15:13] == 3'b001);
            e.rd_en    = re && !we && (a[15:13] == 3'b001);
            e.chk_port = 1'b1;
            e.reg_a    = a[2:0];
            e.wd       = d;
            e.chk_prg  = 1'b1;
            e.prg      = a[14:0];
            rdata_m    = lookup(a);
            if (we && a < 16'h2000) ram_m[a[10:0]] = d;
            if (we && a == 16'h4014) begin
                dma_left = 512;
                dma_page = d;
            end
        end
        exp_q.push_back(e);
        $display("txn %0d addr=%04h wd=%02h we=%0b re=%0b stall_exp=%0b rdata_exp=%02h",
                 cyc, a, d, we, re, e.stall, e.rdata);
    endtask

    // Assert reset asynchronously mid-cycle; outputs must clear before any clock edge.
    task automatic reset_check(input string tag, input logic in_dma);
        @(posedge clk);
        #1;
        cyc++;
        if (in_dma) begin
            chk({tag, "_pre_stall"}, 16'(bus_if.cpu_stall), 16'd1);
            chk({tag, "_pre_wr_en"}, 16'(ppu_wr_en), 16'd1);
        end
        bus_if.mem_addr     = 16'h4000;
        bus_if.mem_wdata    = 8'h00;
        bus_if.mem_write_en = 1'b0;
        bus_if.mem_read_en  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({tag, "_stall"}, 16'(bus_if.cpu_stall), 16'd0);
        chk({tag, "_wr_en"}, 16'(ppu_wr_en), 16'd0);
        chk({tag, "_rdata"}, 16'(bus_if.mem_rdata), 16'd0);
        $display("txn %0d reset %s", cyc, tag);
        dma_left = 0;
        rdata_m  = 8'h00;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        rdata_m = lookup(16'h4000);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("cpu_stall", 16'(bus_if.cpu_stall), 16'(mon_e.stall));
            chk("mem_rdata", 16'(bus_if.mem_rdata), 16'(mon_e.rdata));
            chk("ppu_wr_en", 16'(ppu_wr_en), 16'(mon_e.wr_en));
            chk("ppu_rd_en", 16'(ppu_rd_en), 16'(mon_e.rd_en));
            if (mon_e.chk_port) begin
                chk("ppu_reg_addr", 16'(ppu_reg_addr), 16'(mon_e.reg_a));
                chk("ppu_wr_data", 16'(ppu_wr_data), 16'(mon_e.wd));
            end
            if (mon_e.chk_prg) begin
                chk("prg_addr", 16'(prg_addr), 16'(mon_e.prg));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.mem_addr     = 16'h4000;
        bus_if.mem_wdata    = 8'h00;
        bus_if.mem_write_en = 1'b0;
        bus_if.mem_read_en  = 1'b0;
        dma_left = 0;
        rdata_m  = 8'h00;
        dma_page = 8'h00;

        reset_check("por", 1'b0);

        // Fill RAM through random mirrors so every model location is known.
        for (int i = 0; i < 2048; i++) begin
            drive(16'(i) + 16'(16'h0800 * $urandom_range(0, 3)), 8'($urandom), 1'b1, 1'b0);
        end

        drive(16'h0005, 8'h3C, 1'b1, 1'b0);
        drive(16'h0805, 8'h00, 1'b0, 1'b0);
        drive(16'h1805, 8'h00, 1'b0, 1'b0);
        drive(16'h2002, 8'h00, 1'b0, 1'b1);
        drive(16'h3FFA, 8'h00, 1'b0, 1'b0);
        drive(16'hC123, 8'hFF, 1'b1, 1'b0);
        drive(16'hC123, 8'h00, 1'b0, 1'b0);
        drive(16'h2007, 8'h55, 1'b1, 1'b1);
        drive(16'h4000, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 256; i++) begin
            drive(16'h0200 + 16'(i), 8'(i) ^ 8'hA5, 1'b1, 1'b0);
        end
        drive(16'h4014, 8'h02, 1'b1, 1'b0);
        for (int k = 0; k < 512; k++) begin
            if (k == 37)      drive(16'h0010, 8'hEE, 1'b1, 1'b0);
            else if (k == 99) drive(16'h4014, 8'h05, 1'b1, 1'b0);
            else              drive(rand_addr(), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        drive(16'h0010, 8'h00, 1'b0, 1'b0);
        drive(16'h4000, 8'h00, 1'b0, 1'b0);

        drive(16'h4014, 8'h02, 1'b1, 1'b0);
        for (int k = 0; k < 201; k++) begin
            drive(rand_addr(), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        reset_check("mid_dma", 1'b1);
        for (int i = 0; i < 16; i++) begin
            drive(16'h0200 + 16'(i), 8'h00, 1'b0, 1'($urandom));
        end

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0)
                drive(16'h4014, 8'($urandom), 1'b1, 1'b0);
            else
                drive(rand_addr(), 8'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom));
        end
        while (dma_left > 0) drive(16'h4000, 8'h00, 1'b0, 1'b0);
        drive(16'h4000, 8'h00, 1'b0, 1'b0);
        drive(16'h4000, 8'h00, 1'b0, 1'b0);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
